// File: rtl/adler32_pkg.sv
// Shared constants, FSM state type and modular reduction for the Adler-32 block.
package adler32_pkg;

    localparam logic [16:0] MOD_ADLER = 17'd65521;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Inputs stay below 10*MOD_ADLER (B + 8*A + weighted lane sum), so ten
    // conditional subtractions always give a fully reduced result.
    function automatic logic [15:0] mod_adler(input logic [23:0] x);
        logic [23:0] r;
        r = x;
        for (int unsigned i = 0; i < 10; i++) begin
            if (r >= 24'(MOD_ADLER)) r = r - 24'(MOD_ADLER);
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/adler32_lane_sum.sv
// Per-beat plain and position-weighted byte sums over the first k lanes.
module adler32_lane_sum
    import adler32_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [8*LANES-1:0] data,
    input  logic [3:0]         k,
    output logic [15:0]        sum,
    output logic [15:0]        wsum
);

    always_comb begin
        sum  = '0;
        wsum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (32'(k) > i) begin
                sum  = sum + 16'(data[8*i +: 8]);
                wsum = wsum + (16'(k) - 16'(i)) * 16'(data[8*i +: 8]);
            end
        end
    end

endmodule

// File: rtl/adler32_wide.sv
// Multi-lane Adler-32 engine: length handshake, data beats, one-cycle result strobe.
// Optional ADLER32_WIDE_PROTO_CHECK_EN adds a sticky proto_err output.
module adler32_wide
    import adler32_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int SIZE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               size_valid,
    input  logic [SIZE_W-1:0]  size,
    output logic               size_ready,
    input  logic               data_valid,
    input  logic [8*LANES-1:0] data,
    output logic               data_ready,
    output logic               checksum_valid,
    output logic [31:0]        checksum,
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
    output logic               proto_err,
`endif
    output logic               busy
);

    state_t            state;
    logic [SIZE_W-1:0] remaining;
    logic [15:0]       a;
    logic [15:0]       b;
    logic [3:0]        k;
    logic              last_beat;
    logic [15:0]       lane_sum;
    logic [15:0]       lane_wsum;
    logic [15:0]       a_next;
    logic [15:0]       b_next;

    always_comb begin
        k         = (remaining < SIZE_W'(LANES)) ? 4'(remaining) : 4'(LANES);
        last_beat = (remaining <= SIZE_W'(LANES));
    end

    adler32_lane_sum #(
        .LANES(LANES)
    ) u_lane_sum (
        .data(data),
        .k   (k),
        .sum (lane_sum),
        .wsum(lane_wsum)
    );

    // B advances by k copies of the old A plus each byte weighted by how many
    // per-byte A updates it contributes to within this beat.
    always_comb begin
        a_next = mod_adler(24'(a) + 24'(lane_sum));
        b_next = mod_adler(24'(b) + 24'(k) * 24'(a) + 24'(lane_wsum));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            a         <= 16'd1;
            b         <= '0;
            checksum  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (size_valid) begin
                        a         <= 16'd1;
                        b         <= '0;
                        remaining <= size;
                        if (size == '0) begin
                            state    <= ST_DONE;
                            checksum <= 32'h0000_0001;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_valid) begin
                        a         <= a_next;
                        b         <= b_next;
                        remaining <= remaining - SIZE_W'(k);
                        if (last_beat) begin
                            state    <= ST_DONE;
                            checksum <= {b_next, a_next};
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // size_ready is gated by rst_n so it stays low while reset is held.
    assign size_ready     = rst_n && (state == ST_IDLE);
    assign data_ready     = (state == ST_DATA);
    assign checksum_valid = (state == ST_DONE);
    assign busy           = (state != ST_IDLE);

`ifdef ADLER32_WIDE_PROTO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if ((data_valid && state != ST_DATA) ||
                     (size_valid && state != ST_IDLE)) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adler32_wide.sv
// Self-checking bench for adler32_wide: three lane widths against a byte-serial Adler-32 model.
module tb_adler32_wide;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        size_valid;
    logic [31:0] size;
    logic        data_valid;
    logic [63:0] data;

    logic        sr1, sr4, sr8, dr1, dr4, dr8, cv1, cv4, cv8, bz1, bz4, bz8;
    logic [31:0] cs1, cs4, cs8;
    logic        o_sr, o_dr, o_cv, o_bz;
    logic [31:0] o_cs;
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
    logic        pe1, pe4, pe8, o_pe;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cv_pulses = 0;
    logic [7:0]  msg[$];

    always #5 clk = ~clk;

    adler32_wide #(.LANES(4), .SIZE_W(32)) u_l4 (
        .clk(clk), .rst_n(rst_n),
        .size_valid(size_valid && sel == 4), .size(size), .size_ready(sr4),
        .data_valid(data_valid && sel == 4), .data(data[31:0]), .data_ready(dr4),
        .checksum_valid(cv4), .checksum(cs4),
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
        .proto_err(pe4),
`endif
        .busy(bz4)
    );

    adler32_wide #(.LANES(1), .SIZE_W(32)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .size_valid(size_valid && sel == 1), .size(size), .size_ready(sr1),
        .data_valid(data_valid && sel == 1), .data(data[7:0]), .data_ready(dr1),
        .checksum_valid(cv1), .checksum(cs1),
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
        .proto_err(pe1),
`endif
        .busy(bz1)
    );

    adler32_wide #(.LANES(8), .SIZE_W(32)) u_l8 (
        .clk(clk), .rst_n(rst_n),
        .size_valid(size_valid && sel == 8), .size(size), .size_ready(sr8),
        .data_valid(data_valid && sel == 8), .data(data), .data_ready(dr8),
        .checksum_valid(cv8), .checksum(cs8),
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
        .proto_err(pe8),
`endif
        .busy(bz8)
    );

    assign o_sr = (sel == 1) ? sr1 : (sel == 8) ? sr8 : sr4;
    assign o_dr = (sel == 1) ? dr1 : (sel == 8) ? dr8 : dr4;
    assign o_cv = (sel == 1) ? cv1 : (sel == 8) ? cv8 : cv4;
    assign o_bz = (sel == 1) ? bz1 : (sel == 8) ? bz8 : bz4;
    assign o_cs = (sel == 1) ? cs1 : (sel == 8) ? cs8 : cs4;
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
    assign o_pe = (sel == 1) ? pe1 : (sel == 8) ? pe8 : pe4;
`endif

    always @(posedge clk) if (o_cv === 1'b1) cv_pulses++;

    function automatic logic [31:0] ref_adler();
        logic [31:0] ra, rb;
        ra = 32'd1;
        rb = 32'd0;
        foreach (msg[i]) begin
            ra = (ra + 32'(msg[i])) % 32'd65521;
            rb = (rb + ra) % 32'd65521;
        end
        return {rb[15:0], ra[15:0]};
    endfunction

    task automatic load_str(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    // Runs one message on the selected DUT starting at a negedge in IDLE.
    task automatic drive_msg(input string tag, input logic [31:0] exp, input int gap,
                             input int abort_beats, input bit noise);
        int n, idx, beats, p0;
        n = msg.size(); idx = 0; beats = 0;
        n_checks++;
        if (o_sr !== 1'b1) begin n_fail++; $display("FAIL %s_size_ready: got %b want 1", tag, o_sr); end
        size = 32'(n); size_valid = 1'b1;
        @(negedge clk);
        size_valid = 1'b0;
        p0 = cv_pulses;
        if (n == 0) begin
            n_checks++;
            if (o_dr !== 1'b0) begin n_fail++; $display("FAIL %s_zero_dr: got %b want 0", tag, o_dr); end
        end
        while (idx < n) begin
            for (int g = 0; g < gap; g++) begin
                data_valid = 1'b0;
                if (noise) begin size_valid = 1'b1; size = $urandom; end
                @(negedge clk);
                n_checks++;
                if (o_cv !== 1'b0) begin n_fail++; $display("FAIL %s_gap_cv: got %b want 0", tag, o_cv); end
            end
            n_checks++;
            if (o_dr !== 1'b1) begin n_fail++; $display("FAIL %s_data_ready: got %b want 1", tag, o_dr); end
            data = {$urandom, $urandom};
            for (int l = 0; l < sel; l++) if (idx + l < n) data[8*l +: 8] = msg[idx + l];
            data_valid = 1'b1; size_valid = noise; size = $urandom;
            @(negedge clk);
            idx += sel; beats++;
            data_valid = 1'b0; size_valid = 1'b0;
            if (beats == abort_beats) begin
                rst_n = 1'b0;
                @(negedge clk);
                n_checks++;
                if (o_cv !== 1'b0 || o_bz !== 1'b0 || o_sr !== 1'b0 || o_cs !== 32'h0) begin
                    n_fail++;
                    $display("FAIL %s_abort_rst: cv=%b bz=%b sr=%b cs=%h want 0 0 0 0", tag, o_cv, o_bz, o_sr, o_cs);
                end
                rst_n = 1'b1;
                @(negedge clk);
                n_checks++;
                if (o_sr !== 1'b1 || o_bz !== 1'b0) begin
                    n_fail++; $display("FAIL %s_abort_release: sr=%b bz=%b want 1 0", tag, o_sr, o_bz);
                end
                n_checks++;
                if (cv_pulses != p0) begin
                    n_fail++; $display("FAIL %s_abort_pulses: got %0d want 0", tag, cv_pulses - p0);
                end
                return;
            end
            if (idx < n) begin
                n_checks++;
                if (o_cv !== 1'b0) begin n_fail++; $display("FAIL %s_early_cv: got %b want 0", tag, o_cv); end
            end
        end
        n_checks++;
        if (o_cv !== 1'b1 || o_cs !== exp || o_bz !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_result: cv=%b cs=%h bz=%b want 1 %h 1", tag, o_cv, o_cs, o_bz, exp);
        end
        @(negedge clk);
        n_checks++;
        if (o_cv !== 1'b0 || o_bz !== 1'b0 || o_sr !== 1'b1 || o_cs !== exp) begin
            n_fail++;
            $display("FAIL %s_after: cv=%b bz=%b sr=%b cs=%h want 0 0 1 %h", tag, o_cv, o_bz, o_sr, o_cs, exp);
        end
        n_checks++;
        if (cv_pulses - p0 != 1) begin
            n_fail++; $display("FAIL %s_pulses: got %0d want 1", tag, cv_pulses - p0);
        end
    endtask

    task automatic test_reset();
        sel = 4;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_sr !== 1'b0 || o_dr !== 1'b0 || o_cv !== 1'b0 || o_bz !== 1'b0 || o_cs !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: sr=%b dr=%b cv=%b bz=%b cs=%h want 0 0 0 0 0", o_sr, o_dr, o_cv, o_bz, o_cs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_sr !== 1'b1 || o_bz !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: sr=%b bz=%b want 1 0", o_sr, o_bz);
        end
    endtask

    task automatic test_hello();
        sel = 4;
        load_str("hello");
        drive_msg("hello", 32'h062C0215, 0, -1, 1'b0);
    endtask

    task automatic test_wikipedia_gaps();
        sel = 4;
        load_str("Wikipedia");
        drive_msg("wiki_gap", 32'h11E60398, 3, -1, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_cs !== 32'h11E60398 || o_cv !== 1'b0) begin
            n_fail++; $display("FAIL wiki_hold: cs=%h cv=%b want 11e60398 0", o_cs, o_cv);
        end
    endtask

    task automatic test_zero_size();
        sel = 4;
        msg.delete();
        drive_msg("zero", 32'h0000_0001, 0, -1, 1'b0);
    endtask

    task automatic test_wrap();
        msg.delete();
        for (int i = 0; i < 6000; i++) msg.push_back(8'hFF);
        sel = 1;
        drive_msg("wrap_l1", 32'hA49759EA, 0, -1, 1'b0);
        sel = 8;
        drive_msg("wrap_l8", 32'hA49759EA, 0, -1, 1'b0);
    endtask

    task automatic test_reset_abort();
        sel = 4;
        load_str("Wikipedia");
        drive_msg("abort", 32'h0, 0, 2, 1'b0);
        load_str("hello");
        drive_msg("post_abort", 32'h062C0215, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        int choice, len;
        for (int r = 0; r < 12; r++) begin
            choice = $urandom_range(0, 2);
            sel = (choice == 0) ? 1 : (choice == 1) ? 4 : 8;
            len = $urandom_range(0, 40);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            drive_msg("random", ref_adler(), $urandom_range(0, 2), -1, 1'(r % 2));
        end
    endtask

`ifdef ADLER32_WIDE_PROTO_CHECK_EN
    task automatic test_proto_err();
        sel = 4;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_pe !== 1'b0) begin n_fail++; $display("FAIL proto_clear: got %b want 0", o_pe); end
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        n_checks++;
        if (o_pe !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b want 1", o_pe); end
        load_str("hello");
        drive_msg("proto_hello", 32'h062C0215, 0, -1, 1'b0);
        n_checks++;
        if (o_pe !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b want 1", o_pe); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_pe !== 1'b0) begin n_fail++; $display("FAIL proto_reset: got %b want 0", o_pe); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; sel = 4;
        size_valid = 1'b0; size = '0; data_valid = 1'b0; data = '0;
        test_reset();
        test_hello();
        test_wikipedia_gaps();
        test_zero_size();
        test_wrap();
        test_reset_abort();
        test_random();
`ifdef ADLER32_WIDE_PROTO_CHECK_EN
        test_proto_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
